// File: rtl/apb_initiator.sv
// Single-outstanding APB initiator: a valid/ready request becomes one SETUP/ACCESS
// transfer, and the result comes back on a valid/ready response channel.
// Optional ACCESS-phase timeout abort is enabled with `define APB_TIMEOUT_EN.
module apb_initiator #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]               req_wdata_i,
  input  logic                      req_write_i,
  output logic                      rsp_valid_o,
  output logic [31:0]               rsp_rdata_o,
  output logic                      rsp_err_o,
  input  logic                      rsp_ready_i,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  typedef struct packed {
    logic [APB_ADDR_WIDTH-1:0] addr;
    logic [31:0]               wdata;
    logic                      write;
  } req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  state_t state_q, state_d;
  req_t   req_q;
  rsp_t   rsp_q;
  logic   up_q;
  logic   done, tmo, xfer;

  assign done = (state_q == ACCESS) && PREADY;

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;

  // Abort on the wait cycle whose increment makes the count reach the limit;
  // PREADY in that same cycle wins because tmo requires !PREADY.
  assign tmo = (state_q == ACCESS) && !PREADY && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)                          cnt_q <= '0;
    else if (state_q == SETUP)           cnt_q <= '0;
    else if (state_q == ACCESS && !PREADY) cnt_q <= cnt_q + 1'b1;
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid_i && up_q) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (done || tmo) state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // up_q keeps req_ready_o low during reset and raises it at the first edge after.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= IDLE;
      up_q    <= 1'b0;
      req_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      up_q    <= 1'b1;
      if (state_q == IDLE && req_valid_i && up_q)
        req_q <= '{addr: req_addr_i, wdata: req_wdata_i, write: req_write_i};
      if (done)
        rsp_q <= '{rdata: req_q.write ? 32'h0 : PRDATA, err: PSLVERR};
      else if (tmo)
        rsp_q <= '{rdata: 32'h0, err: 1'b1};
    end
  end

  assign xfer        = (state_q == SETUP) || (state_q == ACCESS);
  assign req_ready_o = up_q && (state_q == IDLE);
  assign PSEL        = xfer;
  assign PENABLE     = (state_q == ACCESS);
  assign PADDR       = xfer ? req_q.addr  : '0;
  assign PWDATA      = xfer ? req_q.wdata : '0;
  assign PWRITE      = xfer & req_q.write;
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rsp_q.rdata;
  assign rsp_err_o   = rsp_q.err;

endmodule

// File: tb/tb_apb_initiator.sv
// Bench for apb_initiator: cycle-stepped APB slave model plus a response scoreboard.
module tb_apb_initiator;
  localparam int AW = 12;
  localparam int TMO = 4;

  logic          HCLK, HRESET;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid, rsp_err, rsp_ready;
  logic [31:0]   rsp_rdata;
  logic [AW-1:0] PADDR;
  logic [31:0]   PWDATA, PRDATA;
  logic          PWRITE, PSEL, PENABLE, PREADY, PSLVERR;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sbq[$];
  int   n_chk, n_err;

  apb_initiator #(.APB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_write_i(req_write),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .rsp_ready_i(rsp_ready),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge HCLK);
    @(negedge HCLK);
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    chk({tag, "_sb_cnt"}, 32'(sbq.size()), 1);
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      chk({tag, "_rdata"}, rsp_rdata, e.rdata);
      chk({tag, "_err"}, 32'(rsp_err), 32'(e.err));
    end
  endtask

  // One full transfer; called at a negedge with the DUT in IDLE.
  task automatic xfer(input logic [AW-1:0] a, input logic [31:0] d, input logic w,
                      input int waits, input logic [31:0] rd, input logic se,
                      input int hold, input bit junk);
    exp_t e;
    e.rdata = w ? 32'h0 : rd;
    e.err   = se;
    sbq.push_back(e);
    req_valid = 1'b1; req_addr = a; req_wdata = d; req_write = w;
    chk("idle_rdy", 32'(req_ready), 1);
    chk("idle_paddr", 32'(PADDR), 0);
    step();
    if (junk) begin
      req_addr = ~a; req_wdata = ~d; req_write = ~w;
    end else req_valid = 1'b0;
    chk("setup_sel_en", 32'({PSEL, PENABLE}), 2);
    chk("setup_paddr", 32'(PADDR), 32'(a));
    chk("setup_pwdata", PWDATA, d);
    chk("setup_pwrite", 32'(PWRITE), 32'(w));
    chk("setup_rdy", 32'(req_ready), 0);
    for (int i = 0; i <= waits; i++) begin
      step();
      chk("acc_sel_en", 32'({PSEL, PENABLE}), 3);
      chk("acc_paddr", 32'(PADDR), 32'(a));
      chk("acc_pwdata", PWDATA, d);
      chk("acc_pwrite", 32'(PWRITE), 32'(w));
      PREADY  = (i == waits);
      PRDATA  = (i == waits) ? rd : 32'hDEAD_BEEF;
      PSLVERR = (i == waits) ? se : 1'b1;
    end
    step();
    PREADY = 1'b0; PSLVERR = 1'b0; req_valid = 1'b0;
    for (int i = 0; i < hold; i++) begin
      chk("bp_valid", 32'(rsp_valid), 1);
      chk("bp_sel_en", 32'({PSEL, PENABLE}), 0);
      chk("bp_rdy", 32'(req_ready), 0);
      if (sbq.size() != 0) begin
        chk("bp_rdata", rsp_rdata, sbq[0].rdata);
        chk("bp_err", 32'(rsp_err), 32'(sbq[0].err));
      end
      step();
    end
    rsp_ready = 1'b1;
    chk("rsp_valid", 32'(rsp_valid), 1);
    chk("rsp_rdy", 32'(req_ready), 0);
    chk("rsp_sel_en", 32'({PSEL, PENABLE}), 0);
    pop_chk("rsp");
    step();
    rsp_ready = 1'b0;
    chk("post_valid", 32'(rsp_valid), 0);
    chk("post_rdy", 32'(req_ready), 1);
    chk("post_psel", 32'(PSEL), 0);
  endtask

  // Issue a read the slave never answers; returns number of ACCESS cycles seen.
  task automatic stall(input logic [AW-1:0] a, input int limit, output int n);
    req_valid = 1'b1; req_addr = a; req_wdata = 32'h5A5A_0000; req_write = 1'b0;
    PREADY = 1'b0;
    chk("st_rdy", 32'(req_ready), 1);
    step();
    req_valid = 1'b0;
    chk("st_setup", 32'({PSEL, PENABLE}), 2);
    n = 0;
    for (int i = 0; i < limit; i++) begin
      step();
      if (PSEL && PENABLE) n++;
      else break;
    end
  endtask

  task automatic rst_pulse;
    HRESET = 1'b1;
    #1;
    chk("rst_sel_en", 32'({PSEL, PENABLE}), 0);
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_rdy", 32'(req_ready), 0);
    chk("rst_paddr", 32'(PADDR), 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", 32'(rsp_err), 0);
    step();
    HRESET = 1'b0;
    chk("rst_rel_valid", 32'(rsp_valid), 0);
    step();
    chk("rst_rel_rdy", 32'(req_ready), 1);
    chk("rst_rel_valid2", 32'(rsp_valid), 0);
    chk("rst_sb_empty", 32'(sbq.size()), 0);
  endtask

  initial begin
    int n;
    n_chk = 0; n_err = 0;
    HRESET = 1'b1;
    req_valid = 1'b0; req_addr = '0; req_wdata = '0; req_write = 1'b0;
    rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    #2;
    chk("reset_rdy", 32'(req_ready), 0);
    chk("reset_sel_en", 32'({PSEL, PENABLE}), 0);
    chk("reset_valid", 32'(rsp_valid), 0);
    chk("reset_pwdata", PWDATA, 0);
    chk("reset_pwrite", 32'(PWRITE), 0);
    @(negedge HCLK);
    HRESET = 1'b0;
    step();
    chk("reset_rel_rdy", 32'(req_ready), 1);

    xfer(12'h000, 32'h0000_0003, 1'b1, 0, 32'h1111_2222, 1'b0, 0, 1'b0);
    xfer(12'h004, 32'h0, 1'b0, 3, 32'h0000_0002, 1'b0, 0, 1'b0);
    xfer(12'h008, 32'h0, 1'b0, 0, 32'hCAFE_F00D, 1'b1, 0, 1'b0);
    xfer(12'h00C, 32'hA5A5_5A5A, 1'b1, 1, 32'h7777_7777, 1'b0, 5, 1'b1);
    xfer(12'hFFC, 32'h0, 1'b0, 2, 32'h8000_0001, 1'b1, 5, 1'b0);
    for (int k = 0; k < 6; k++)
      xfer(AW'($urandom), $urandom, 1'($urandom), int'($urandom_range(0, 4)),
           $urandom, 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));

`ifdef APB_TIMEOUT_EN
    begin
      exp_t e;
      e.rdata = 32'h0; e.err = 1'b1;
      sbq.push_back(e);
      PRDATA = 32'h1234_5678;
      stall(12'h010, 20, n);
      chk("tmo_access_cycles", 32'(n), TMO);
      chk("tmo_valid", 32'(rsp_valid), 1);
      chk("tmo_sel_en", 32'({PSEL, PENABLE}), 0);
      rsp_ready = 1'b1;
      pop_chk("tmo");
      step();
      rsp_ready = 1'b0;
      chk("tmo_post_rdy", 32'(req_ready), 1);
    end
    // PREADY on the last allowed wait cycle completes normally
    xfer(12'h014, 32'h0, 1'b0, TMO - 1, 32'h0000_00AB, 1'b0, 0, 1'b0);
    stall(12'h018, 2, n);
    chk("rst_mid_cycles", 32'(n), 2);
    rst_pulse();
`else
    stall(12'h010, 1000, n);
    chk("noto_access_cycles", 32'(n), 1000);
    chk("noto_valid", 32'(rsp_valid), 0);
    rst_pulse();
`endif
    xfer(12'h020, 32'h0, 1'b0, 0, 32'h0BAD_CAFE, 1'b0, 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got timeout required completion");
    $fatal(1);
  end
endmodule

// File: doc/apb_initiator.md
APB_INITIATOR -- requirements
Module: apb_initiator

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 12, meaning the APB address width in bits.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of PREADY-low ACCESS cycles before abort.
REQ-003 SHALL have port HCLK  input  1  the single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port HRESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid_i  input  1  a transfer request is presented.
REQ-006 SHALL have port req_ready_o  output  1  the request is accepted this cycle.
REQ-007 SHALL have ports req_addr_i  input  APB_ADDR_WIDTH, req_wdata_i  input  32, and req_write_i  input  1 (1=write); together these form the request payload.
REQ-008 SHALL have ports rsp_valid_o  output  1, rsp_rdata_o  output  32, rsp_err_o  output  1, and rsp_ready_i  input  1; together these form the response channel.
REQ-009 SHALL have ports PADDR  output  APB_ADDR_WIDTH, PWDATA  output  32, PWRITE  output  1, PSEL  output  1, PENABLE  output  1.
REQ-010 SHALL have ports PRDATA  input  32, PREADY  input  1, PSLVERR  input  1.

Function
REQ-011 SHALL implement the states IDLE, SETUP, ACCESS and RESP.
REQ-012 SHALL assert req_ready_o only in IDLE; when req_valid_i&&req_ready_o, it SHALL register addr/wdata/write and enter SETUP on the next cycle.
REQ-013 In SETUP, SHALL drive PSEL=1 and PENABLE=0, then unconditionally enter ACCESS.
REQ-014 In ACCESS, SHALL drive PSEL=1 and PENABLE=1, and remain in ACCESS while PREADY=0.
REQ-015 In ACCESS with PREADY=1, SHALL capture PRDATA (reads only; 0 for writes) and PSLVERR into the response register and enter RESP.
REQ-016 SHALL hold PADDR, PWDATA and PWRITE stable from SETUP through the final ACCESS cycle, and SHALL drive them to 0 in IDLE.
REQ-017 In RESP, SHALL drive PSEL=0 and PENABLE=0 with rsp_valid_o=1; rsp_rdata_o and rsp_err_o SHALL be stable until rsp_ready_i=1, then enter IDLE.
REQ-018 Minimum latency SHALL be: accept in cycle N, SETUP in N+1, ACCESS in N+2, rsp_valid_o in N+3 (zero-wait slave).
REQ-019 A response with rsp_valid_o and rsp_ready_i both high in the same cycle SHALL complete; the next request SHALL be accepted no earlier than the following cycle (IDLE).
REQ-020 SHALL never assert PENABLE without PSEL, and SHALL never issue back-to-back transfers without an IDLE/RESP gap.
REQ-021 An illegal state encoding SHALL return to IDLE.
REQ-022 Request inputs outside IDLE SHALL be ignored.

Reset
REQ-023 While HRESET=1, SHALL force state=IDLE and the outputs req_ready_o=0, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, PSEL=0, PENABLE=0, PADDR=0, PWDATA=0, PWRITE=0, and the timeout counter=0.
REQ-024 After reset deassertion, req_ready_o SHALL be 1 from the first clock edge.
REQ-025 Reset asserted mid-transfer SHALL immediately (asynchronously) drop PSEL/PENABLE and discard the transfer, with no response issued.

Configuration
REQ-026 When APB_TIMEOUT_EN is defined, a counter of width $clog2(TIMEOUT_CYCLES+1) SHALL clear on entry to ACCESS and increment each ACCESS cycle with PREADY=0.
REQ-027 With APB_TIMEOUT_EN defined and the counter reaching TIMEOUT_CYCLES while PREADY=0, SHALL end the transfer (PSEL=0, PENABLE=0) next cycle and enter RESP with rsp_err_o=1 and rsp_rdata_o=0.
REQ-028 With APB_TIMEOUT_EN defined, PREADY=1 in the same cycle as the counter reaching TIMEOUT_CYCLES SHALL complete normally, with the slave response taking priority.
REQ-029 When APB_TIMEOUT_EN is undefined, SHALL wait in ACCESS indefinitely, with no counter logic present.

Verification
REQ-030 Write test: addr=0x000, wdata=0x0000_0003, zero-wait slave -> PSEL cycle N+1, PENABLE cycle N+2, PWDATA=0x3 stable, rsp_valid_o at N+3, rsp_err_o=0.
REQ-031 Read test: addr=0x004, slave PRDATA=0x0000_0002 after 3 wait cycles -> ACCESS lasts 4 cycles, rsp_rdata_o=0x2, rsp_err_o=0.
REQ-032 Error test: slave PSLVERR=1 with PREADY=1 -> rsp_err_o=1, and the next request is accepted after rsp_ready_i.
REQ-033 Backpressure test: rsp_ready_i=0 for 5 cycles -> rsp_valid_o, rsp_rdata_o and rsp_err_o held, req_ready_o=0, APB idle throughout.
REQ-034 Timeout test (APB_TIMEOUT_EN, TIMEOUT_CYCLES=4): PREADY stuck 0 -> abort after 4 wait cycles, rsp_err_o=1, rsp_rdata_o=0; without the macro, ACCESS persists for 1000 cycles.
REQ-035 Reset test: HRESET pulse during ACCESS -> PSEL=0 and PENABLE=0 immediately, no rsp_valid_o, and req_ready_o=1 after release.
